lane_engine: RTL



---
 rtl/frogger_pkg.sv | 19 +
 rtl/lane_engine_tick_divider.sv | 27 ++
 rtl/lane_engine.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/frogger_pkg.sv
// Shared types and lane tables for the Frogger field generator.
// Lane tables are packed [6:1] so lane n is indexed directly by its row number.
package frogger_pkg;

  typedef enum logic [1:0] {RUN, HIT, WIN} state_t;

  localparam logic [6:1][7:0] LANE_INIT = {
    8'b0000_1110, 8'b1001_0010, 8'b0110_0000,
    8'b1000_1000, 8'b0011_0011, 8'b1100_0000
  };

  localparam logic [6:1][1:0] LANE_SPEED = {
    2'd3, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1
  };

  // 1 = rotate left (odd lanes), 0 = rotate right (even lanes)
  localparam logic [6:1] LANE_DIR = 6'b01_0101;

endpackage

// File: rtl/lane_engine_tick_divider.sv
// Base scroll tick generator: one-cycle tick every STEP_CYCLES enabled cycles.
module tick_divider #(
  parameter int STEP_CYCLES = 12500000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(STEP_CYCLES);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(STEP_CYCLES - 1));
  assign tick   = en & w_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lane_engine.sv
// Frogger field generator: scrolling lanes, frog overlay, collision/goal
// detection and hit/win animations, producing registered row bytes.
module lane_engine
  import frogger_pkg::*;
#(
  parameter int STEP_CYCLES = 12500000,
  parameter int HIT_STEPS   = 4,
  parameter int WIN_STEPS   = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] frog_x,
  input  logic [2:0] frog_y,
  output logic [7:0] fila_0,
  output logic [7:0] fila_1,
  output logic [7:0] fila_2,
  output logic [7:0] fila_3,
  output logic [7:0] fila_4,
  output logic [7:0] fila_5,
  output logic [7:0] fila_6,
  output logic [7:0] fila_7,
  output logic       collision,
  output logic       win,
  output logic       frog_reset,
  output logic [3:0] score
);

  localparam int MAX_STEPS = (HIT_STEPS > WIN_STEPS) ? HIT_STEPS : WIN_STEPS;
  localparam int SW        = $clog2(MAX_STEPS) + 1;

  state_t        r_state;
  logic [SW-1:0] r_step;
  logic [7:0]    r_lane [1:6];
  logic [1:0]    r_sub  [1:6];
  logic [7:0]    r_fila [0:7];
  logic          r_collision;
  logic          r_win;
  logic          r_frog_reset;
  logic [3:0]    r_score;

  logic          w_tick;
  logic [7:0]    w_rows [0:7];
  logic          w_hit;
  logic          w_last_step;
  logic          w_frog_vis;
  logic [7:0]    w_frog_mask;

  tick_divider #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .en   (enable),
    .tick (w_tick)
  );

  // Rows 0 and 7 are safe rows with no traffic, so they never collide.
  always_comb begin
    w_rows[0] = 8'h00;
    w_rows[7] = 8'h00;
    for (int n = 1; n <= 6; n++) begin
      w_rows[n] = r_lane[n];
    end
  end

  assign w_hit       = w_rows[frog_y][frog_x];
  assign w_last_step = (r_state == HIT) ? (r_step == SW'(HIT_STEPS - 1))
                                        : (r_step == SW'(WIN_STEPS - 1));
  assign w_frog_vis  = (r_state == RUN) | ((r_state == HIT) & ~r_step[0]);
  assign w_frog_mask = 8'h01 << frog_x;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RUN;
      r_step       <= '0;
      r_collision  <= 1'b0;
      r_win        <= 1'b0;
      r_frog_reset <= 1'b0;
      r_score      <= 4'd0;
      for (int n = 1; n <= 6; n++) begin
        r_lane[n] <= LANE_INIT[n];
        r_sub[n]  <= 2'd0;
      end
    end else begin
      r_collision  <= 1'b0;
      r_win        <= 1'b0;
      r_frog_reset <= 1'b0;
      case (r_state)
        RUN: begin
          if (w_tick) begin
            for (int n = 1; n <= 6; n++) begin
              if (r_sub[n] == LANE_SPEED[n] - 2'd1) begin
                r_lane[n] <= LANE_DIR[n] ? {r_lane[n][6:0], r_lane[n][7]}
                                         : {r_lane[n][0], r_lane[n][7:1]};
                r_sub[n]  <= 2'd0;
              end else begin
                r_sub[n]  <= r_sub[n] + 2'd1;
              end
            end
          end
          // Check runs on pre-shift lanes; a post-shift overlap is caught next cycle.
          if (w_hit) begin
            r_collision <= 1'b1;
            r_state     <= HIT;
            r_step      <= '0;
          end else if (frog_y == 3'd7) begin
            r_win   <= 1'b1;
            r_score <= (r_score == 4'hF) ? r_score : r_score + 4'd1;
            r_state <= WIN;
            r_step  <= '0;
          end
        end
        HIT, WIN: begin
          if (w_tick) begin
            if (w_last_step) begin
              for (int n = 1; n <= 6; n++) begin
                r_lane[n] <= LANE_INIT[n];
                r_sub[n]  <= 2'd0;
              end
              r_frog_reset <= 1'b1;
              r_state      <= RUN;
              r_step       <= '0;
            end else begin
              r_step <= r_step + 1'b1;
            end
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // Frame stage: one-cycle registered view of lanes, frog and animation.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 8; r++) begin
        r_fila[r] <= 8'h00;
      end
    end else begin
      for (int r = 0; r < 8; r++) begin
        if (r_state == WIN) begin
          r_fila[r] <= r_step[0] ? 8'h00 : 8'hFF;
        end else if (w_frog_vis && (frog_y == 3'(r))) begin
          r_fila[r] <= w_rows[r] | w_frog_mask;
        end else begin
          r_fila[r] <= w_rows[r];
        end
      end
    end
  end

  assign fila_0     = r_fila[0];
  assign fila_1     = r_fila[1];
  assign fila_2     = r_fila[2];
  assign fila_3     = r_fila[3];
  assign fila_4     = r_fila[4];
  assign fila_5     = r_fila[5];
  assign fila_6     = r_fila[6];
  assign fila_7     = r_fila[7];
  assign collision  = r_collision;
  assign win        = r_win;
  assign frog_reset = r_frog_reset;
  assign score      = r_score;

endmodule
